nand_op_sequencer: RTL and testbench
====================================

NAND_OP_SEQUENCER -- requirements
Module: nand_op_sequencer

Interface
REQ-001 Parameter MAX_POLLS, default 1024: max GET_FEATURE status polls per operation before timeout.
REQ-002 Parameter POLL_GAP, default 16: idle clocks between successive status polls.
REQ-003 i_Clk  in  1  sole clock, all logic on rising edge.
REQ-004 i_Rst  in  1  asynchronous, active-high reset.
REQ-005 i_Op_Start  in  1  one-cycle request, sampled only in IDLE.
REQ-006 i_Op_Type  in  2  00 page program, 01 page read, 10 block erase, 11 reserved.
REQ-007 i_Row_Addr  in  24  page/block row address.
REQ-008 i_Col_Addr  in  13  cache column address.
REQ-009 o_Op_Busy  out  1  high from the cycle after an accepted start until the cycle o_Op_Done pulses.
REQ-010 o_Op_Done  out  1  one-cycle completion pulse.
REQ-011 o_Op_Fail  out  1  valid with o_Op_Done: device fail, timeout or reserved type.
REQ-012 o_Op_Timeout  out  1  valid with o_Op_Done: poll limit reached.
REQ-013 o_Status  out  8  last status byte captured, held until the next capture or reset.
REQ-014 o_Command  out  8  opcode to the SPI command stage.
REQ-015 o_CM_DV  out  1  one-cycle command-valid pulse.
REQ-016 o_Addr_Data  out  24  address/data to the command stage, data in LSB byte.
REQ-017 i_CM_Ready  in  1  command stage idle; combinationally low in the cycle o_CM_DV is high.
REQ-018 i_RX_Feature_Byte  in  8  feature byte returned by GET_FEATURE.
REQ-019 i_RX_Feature_DV  in  1  one-cycle valid for i_RX_Feature_Byte.

Function
REQ-020 Opcodes: WRITE_ENABLE 0x06, PROG_LOAD1 0x02, PROG_EXEC 0x10, PAGE_READ 0x13, CACHE_READ 0x03, BLOCK_ERASE 0xD8, GET_FEATURE 0x0F.
REQ-021 Program sequence: WRITE_ENABLE, PROG_LOAD1 {11'b0,col}, PROG_EXEC row, poll.
REQ-022 Read sequence: PAGE_READ row, poll, CACHE_READ {11'b0,col}.
REQ-023 Erase sequence: WRITE_ENABLE, BLOCK_ERASE row, poll.
REQ-024 Start latches type, row and col; i_Op_Start while busy is ignored, with no latch and no effect.
REQ-025 Reserved type 11: no command issued; Done+Fail pulse 1 cycle after start.
REQ-026 States: IDLE, ISSUE, ACK, WAIT_RDY, WAIT_FEAT, GAP, FINISH.
REQ-027 ISSUE: when i_CM_Ready=1, drive o_CM_DV=1 for one cycle with o_Command/o_Addr_Data valid; go to ACK.
REQ-028 ACK lasts exactly one cycle and ignores i_CM_Ready. Non-GET_FEATURE commands then go to WAIT_RDY. GET_FEATURE goes to WAIT_FEAT.
REQ-029 WAIT_RDY: on i_CM_Ready=1, advance to the next step's ISSUE, or to FINISH after the final command.
REQ-030 Poll command: GET_FEATURE with o_Addr_Data=24'h00C000, status register address 0xC0 in bits [15:8].
REQ-031 WAIT_FEAT: on i_RX_Feature_DV, capture the byte into o_Status and increment the 11-bit poll counter.
REQ-032 Status bit0 (OIP)=0: poll ends; continue the sequence, or FINISH for program and erase.
REQ-033 OIP=1 and count<MAX_POLLS: enter GAP for POLL_GAP cycles, then ISSUE GET_FEATURE.
REQ-034 OIP=1 and count==MAX_POLLS: FINISH with Fail=1 and Timeout=1; no further commands.
REQ-035 The poll counter clears at each start; it never wraps.
REQ-036 Fail conditions: program on status bit3 (P_FAIL), erase on bit2 (E_FAIL), read on status[5:4]==2'b10 (uncorrectable ECC).
REQ-037 On read fail, CACHE_READ is still issued.
REQ-038 FINISH: pulse o_Op_Done one cycle with o_Op_Fail/o_Op_Timeout; return to IDLE.
REQ-039 o_Op_Fail and o_Op_Timeout are 0 whenever o_Op_Done=0.
REQ-040 o_Command and o_Addr_Data hold their last value between pulses.
REQ-041 i_RX_Feature_DV outside WAIT_FEAT is ignored.

Reset
REQ-042 i_Rst=1: state IDLE immediately, asynchronously.
REQ-043 i_Rst=1: all outputs 0 (o_Command 0x00, o_Addr_Data 0, o_Status 0x00) and the poll counter 0.
REQ-044 Reset mid-operation aborts the operation with no Done pulse; the first start after reset release is accepted normally.

Verification
REQ-045 Program, row 0x000123, col 0x0040, one poll returning 0x00 -> commands 06, 02/000040, 10/000123, 0F/00C000; Done=1, Fail=0.
REQ-046 Erase, polls return 0x01, 0x01, 0x04 -> three GET_FEATUREs spaced by POLL_GAP idle cycles; Done with Fail=1; o_Status=0x04.
REQ-047 Read, poll returns 0x20 -> PAGE_READ, GET_FEATURE, then CACHE_READ/col; Done with Fail=1.
REQ-048 MAX_POLLS=3, OIP always 1 -> exactly 3 polls; Done with Fail=1 and Timeout=1.
REQ-049 i_CM_Ready held low 50 cycles after each command, plus a second i_Op_Start while busy -> no extra DV pulses and the second start is ignored.
REQ-050 i_Rst asserted during WAIT_FEAT -> outputs 0 and no Done; a new start after release runs a correct full program sequence.

Source files
------------

// File: rtl/nand_op_sequencer.sv
// Sequences SPI-NAND program / read / erase operations as command steps,
// polling the status feature register until the device reports not-busy.
`timescale 1ns/1ps
module nand_op_sequencer #(
    parameter int MAX_POLLS = 1024,
    parameter int POLL_GAP  = 16
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic        i_Op_Start,
    input  logic [1:0]  i_Op_Type,
    input  logic [23:0] i_Row_Addr,
    input  logic [12:0] i_Col_Addr,
    output logic        o_Op_Busy,
    output logic        o_Op_Done,
    output logic        o_Op_Fail,
    output logic        o_Op_Timeout,
    output logic [7:0]  o_Status,
    output logic [7:0]  o_Command,
    output logic        o_CM_DV,
    output logic [23:0] o_Addr_Data,
    input  logic        i_CM_Ready,
    input  logic [7:0]  i_RX_Feature_Byte,
    input  logic        i_RX_Feature_DV
);

    localparam logic [7:0]  LP_WRITE_ENABLE = 8'h06;
    localparam logic [7:0]  LP_PROG_LOAD1   = 8'h02;
    localparam logic [7:0]  LP_PROG_EXEC    = 8'h10;
    localparam logic [7:0]  LP_PAGE_READ    = 8'h13;
    localparam logic [7:0]  LP_CACHE_READ   = 8'h03;
    localparam logic [7:0]  LP_BLOCK_ERASE  = 8'hD8;
    localparam logic [7:0]  LP_GET_FEATURE  = 8'h0F;
    localparam logic [23:0] LP_STATUS_ADDR  = 24'h00C000;
    localparam logic [10:0] LP_MAX_POLLS    = 11'(MAX_POLLS);
    localparam logic [15:0] LP_GAP_LAST     = 16'(POLL_GAP - 1);

    typedef enum logic [2:0] {
        IDLE, ISSUE, ACK, WAIT_RDY, WAIT_FEAT, GAP, FINISH
    } state_t;

    state_t      r_State, w_Next;
    logic [1:0]  r_Type;
    logic [23:0] r_Row;
    logic [12:0] r_Col;
    logic [1:0]  r_Step;
    logic [10:0] r_Polls;
    logic [15:0] r_Gap;
    logic        r_Fail, r_Timeout, r_CM_DV;
    logic [7:0]  r_Command, r_Status;
    logic [23:0] r_Addr_Data;
    logic        w_Accept, w_Issue, w_Step_Inc, w_Capture, w_Set_Fail, w_Set_Timeout;
    logic [10:0] w_Polls_Next;

    // Step tables: program = WE, LOAD, EXEC, poll; read = PAGE_READ, poll, CACHE_READ; erase = WE, ERASE, poll
    function automatic logic [7:0] f_Opcode(input logic [1:0] t, input logic [1:0] s);
        case ({t, s})
            4'b00_00, 4'b10_00:            f_Opcode = LP_WRITE_ENABLE;
            4'b00_01:                      f_Opcode = LP_PROG_LOAD1;
            4'b00_10:                      f_Opcode = LP_PROG_EXEC;
            4'b01_00:                      f_Opcode = LP_PAGE_READ;
            4'b01_10:                      f_Opcode = LP_CACHE_READ;
            4'b10_01:                      f_Opcode = LP_BLOCK_ERASE;
            4'b00_11, 4'b01_01, 4'b10_10: f_Opcode = LP_GET_FEATURE;
            default:                       f_Opcode = 8'h00;
        endcase
    endfunction

    function automatic logic f_Is_Poll(input logic [1:0] t, input logic [1:0] s);
        f_Is_Poll = ({t, s} == 4'b00_11) || ({t, s} == 4'b01_01) || ({t, s} == 4'b10_10);
    endfunction

    function automatic logic f_Is_Last(input logic [1:0] t, input logic [1:0] s);
        f_Is_Last = ({t, s} == 4'b00_11) || ({t, s} == 4'b01_10) || ({t, s} == 4'b10_10);
    endfunction

    function automatic logic [23:0] f_Addr(input logic [1:0] t, input logic [1:0] s,
                                           input logic [23:0] row, input logic [12:0] col);
        case ({t, s})
            4'b00_01, 4'b01_10:           f_Addr = {11'b0, col};
            4'b00_10, 4'b01_00, 4'b10_01: f_Addr = row;
            4'b00_11, 4'b01_01, 4'b10_10: f_Addr = LP_STATUS_ADDR;
            default:                      f_Addr = 24'h000000;
        endcase
    endfunction

    function automatic logic f_Dev_Fail(input logic [1:0] t, input logic [7:0] st);
        case (t)
            2'b00:   f_Dev_Fail = st[3];
            2'b01:   f_Dev_Fail = (st[5:4] == 2'b10);
            2'b10:   f_Dev_Fail = st[2];
            default: f_Dev_Fail = 1'b1;
        endcase
    endfunction

    function automatic logic [10:0] f_Sat_Inc(input logic [10:0] v);
        f_Sat_Inc = (v == 11'h7FF) ? v : v + 11'd1;
    endfunction

    assign w_Polls_Next = f_Sat_Inc(r_Polls);

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) r_State <= IDLE;
        else       r_State <= w_Next;
    end

    always_comb begin
        w_Next        = r_State;
        w_Accept      = 1'b0;
        w_Issue       = 1'b0;
        w_Step_Inc    = 1'b0;
        w_Capture     = 1'b0;
        w_Set_Fail    = 1'b0;
        w_Set_Timeout = 1'b0;
        case (r_State)
            IDLE: if (i_Op_Start) begin
                w_Accept = 1'b1;
                w_Next   = (i_Op_Type == 2'b11) ? FINISH : ISSUE;
            end
            ISSUE: if (i_CM_Ready) begin
                w_Issue = 1'b1;
                w_Next  = ACK;
            end
            ACK: w_Next = f_Is_Poll(r_Type, r_Step) ? WAIT_FEAT : WAIT_RDY;
            WAIT_RDY: if (i_CM_Ready) begin
                if (f_Is_Last(r_Type, r_Step)) begin
                    w_Next = FINISH;
                end else begin
                    w_Step_Inc = 1'b1;
                    w_Next     = ISSUE;
                end
            end
            WAIT_FEAT: if (i_RX_Feature_DV) begin
                w_Capture = 1'b1;
                if (!i_RX_Feature_Byte[0]) begin
                    w_Set_Fail = f_Dev_Fail(r_Type, i_RX_Feature_Byte);
                    if (f_Is_Last(r_Type, r_Step)) begin
                        w_Next = FINISH;
                    end else begin
                        w_Step_Inc = 1'b1;
                        w_Next     = ISSUE;
                    end
                end else if (w_Polls_Next >= LP_MAX_POLLS) begin
                    w_Set_Fail    = 1'b1;
                    w_Set_Timeout = 1'b1;
                    w_Next        = FINISH;
                end else begin
                    w_Next = (POLL_GAP == 0) ? ISSUE : GAP;
                end
            end
            GAP: if (r_Gap == LP_GAP_LAST) w_Next = ISSUE;
            FINISH: w_Next = IDLE;
            default: w_Next = IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_Type      <= 2'b00;
            r_Row       <= '0;
            r_Col       <= '0;
            r_Step      <= 2'b00;
            r_Polls     <= '0;
            r_Gap       <= '0;
            r_Fail      <= 1'b0;
            r_Timeout   <= 1'b0;
            r_CM_DV     <= 1'b0;
            r_Command   <= 8'h00;
            r_Addr_Data <= '0;
            r_Status    <= 8'h00;
        end else begin
            r_CM_DV <= w_Issue;
            if (w_Accept) begin
                r_Type    <= i_Op_Type;
                r_Row     <= i_Row_Addr;
                r_Col     <= i_Col_Addr;
                r_Step    <= 2'b00;
                r_Polls   <= '0;
                r_Fail    <= (i_Op_Type == 2'b11);
                r_Timeout <= 1'b0;
            end
            if (w_Issue) begin
                r_Command   <= f_Opcode(r_Type, r_Step);
                r_Addr_Data <= f_Addr(r_Type, r_Step, r_Row, r_Col);
            end
            if (w_Step_Inc) r_Step <= r_Step + 2'd1;
            if (w_Capture) begin
                r_Status <= i_RX_Feature_Byte;
                r_Polls  <= w_Polls_Next;
            end
            if (w_Set_Fail)    r_Fail    <= 1'b1;
            if (w_Set_Timeout) r_Timeout <= 1'b1;
            r_Gap <= (r_State == GAP) ? r_Gap + 16'd1 : 16'd0;
        end
    end

    assign o_Op_Busy    = (r_State != IDLE);
    assign o_Op_Done    = (r_State == FINISH);
    assign o_Op_Fail    = o_Op_Done & r_Fail;
    assign o_Op_Timeout = o_Op_Done & r_Timeout;
    assign o_Status     = r_Status;
    assign o_Command    = r_Command;
    assign o_CM_DV      = r_CM_DV;
    assign o_Addr_Data  = r_Addr_Data;

endmodule

// File: tb/tb_nand_op_sequencer.sv
// Bench for nand_op_sequencer: command-stage/device responder plus a
// sequence-level reference model built from the operation rules.
`timescale 1ns/1ps
module tb_nand_op_sequencer;

    localparam int TB_MAX_POLLS = 3;
    localparam int TB_POLL_GAP  = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_Op_Start;
    logic [1:0]  i_Op_Type;
    logic [23:0] i_Row_Addr;
    logic [12:0] i_Col_Addr;
    logic        o_Op_Busy, o_Op_Done, o_Op_Fail, o_Op_Timeout;
    logic [7:0]  o_Status, o_Command;
    logic        o_CM_DV;
    logic [23:0] o_Addr_Data;
    logic        i_CM_Ready;
    logic [7:0]  i_RX_Feature_Byte;
    logic        i_RX_Feature_DV;

    logic        ready_base, resp_dv, stray_dv;
    logic [7:0]  resp_byte, stray_byte;

    assign i_CM_Ready        = ready_base & ~o_CM_DV;
    assign i_RX_Feature_DV   = resp_dv | stray_dv;
    assign i_RX_Feature_Byte = stray_dv ? stray_byte : resp_byte;

    always #5 clk = ~clk;

    nand_op_sequencer #(.MAX_POLLS(TB_MAX_POLLS), .POLL_GAP(TB_POLL_GAP)) dut (
        .i_Clk(clk), .i_Rst(rst), .i_Op_Start(i_Op_Start), .i_Op_Type(i_Op_Type),
        .i_Row_Addr(i_Row_Addr), .i_Col_Addr(i_Col_Addr), .o_Op_Busy(o_Op_Busy),
        .o_Op_Done(o_Op_Done), .o_Op_Fail(o_Op_Fail), .o_Op_Timeout(o_Op_Timeout),
        .o_Status(o_Status), .o_Command(o_Command), .o_CM_DV(o_CM_DV),
        .o_Addr_Data(o_Addr_Data), .i_CM_Ready(i_CM_Ready),
        .i_RX_Feature_Byte(i_RX_Feature_Byte), .i_RX_Feature_DV(i_RX_Feature_DV)
    );

    typedef struct { logic [7:0] cmd; logic [23:0] addr; int cyc; } cmd_t;
    typedef struct { logic [7:0] cmd; logic [23:0] addr; bit chk_addr; } exp_t;

    int         cm_delay, feat_delay;
    logic [7:0] stat_list[$];
    cmd_t       log_q[$];
    int         feat_q[$];
    int         cyc, done_cnt, flag_err;
    logic       done_fail, done_to;
    int         checks, failures;
    exp_t       exp_q[$];
    logic       exp_fail, exp_to;
    logic [7:0] exp_status;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Command stage + flash device: ready drops for cm_delay after each command,
    // status bytes come back feat_delay cycles after each GET_FEATURE.
    initial begin
        int busy_cnt, feat_cnt, resp_idx;
        busy_cnt = 0; feat_cnt = 0; resp_idx = 0;
        ready_base = 1'b1; resp_dv = 1'b0; resp_byte = 8'h00;
        cyc = 0; done_cnt = 0; flag_err = 0; done_fail = 1'b0; done_to = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                busy_cnt = 0; feat_cnt = 0; resp_idx = 0;
                resp_dv = 1'b0; ready_base = 1'b1;
            end else begin
                if (!o_Op_Busy) resp_idx = 0;
                if (o_CM_DV) begin
                    log_q.push_back('{o_Command, o_Addr_Data, cyc});
                    busy_cnt = cm_delay;
                    if (o_Command == 8'h0F) feat_cnt = feat_delay;
                end
                if (o_Op_Done) begin
                    done_cnt++;
                    done_fail = o_Op_Fail;
                    done_to   = o_Op_Timeout;
                end
                if (!o_Op_Done && (o_Op_Fail || o_Op_Timeout)) flag_err++;
                resp_dv = 1'b0;
                if (feat_cnt > 0) begin
                    feat_cnt--;
                    if (feat_cnt == 0) begin
                        resp_dv   = 1'b1;
                        resp_byte = (resp_idx < stat_list.size()) ? stat_list[resp_idx] : 8'h00;
                        resp_idx++;
                        feat_q.push_back(cyc);
                    end
                end
                if (busy_cnt > 0) busy_cnt--;
                ready_base = (busy_cnt == 0);
            end
        end
    end

    task automatic push_exp(input logic [7:0] c, input logic [23:0] a, input bit chk);
        exp_q.push_back('{c, a, chk});
    endtask

    // Expected command list and outcome, from the per-operation rules
    task automatic model_op(input logic [1:0] t, input logic [23:0] row, input logic [12:0] col);
        logic [7:0] s;
        bit to;
        exp_q.delete();
        exp_fail = 1'b0; exp_to = 1'b0; s = 8'h00; to = 1'b0;
        if (t == 2'b11) begin
            exp_fail = 1'b1;
            return;
        end
        if (t == 2'b00) begin
            push_exp(8'h06, 24'h0, 1'b0);
            push_exp(8'h02, {11'b0, col}, 1'b1);
            push_exp(8'h10, row, 1'b1);
        end else if (t == 2'b01) begin
            push_exp(8'h13, row, 1'b1);
        end else begin
            push_exp(8'h06, 24'h0, 1'b0);
            push_exp(8'hD8, row, 1'b1);
        end
        for (int i = 0; i < TB_MAX_POLLS; i++) begin
            push_exp(8'h0F, 24'h00C000, 1'b1);
            s = (i < stat_list.size()) ? stat_list[i] : 8'h00;
            exp_status = s;
            if (!s[0]) break;
            if (i == TB_MAX_POLLS - 1) to = 1'b1;
        end
        if (to) begin
            exp_fail = 1'b1;
            exp_to   = 1'b1;
        end else if (t == 2'b00) begin
            exp_fail = s[3];
        end else if (t == 2'b01) begin
            exp_fail = (s[5:4] == 2'b10);
            push_exp(8'h03, {11'b0, col}, 1'b1);
        end else begin
            exp_fail = s[2];
        end
    endtask

    task automatic run_op(input string nm, input logic [1:0] t, input logic [23:0] row,
                          input logic [12:0] col, input bit second);
        int lb, fb, d0, n, kp;
        model_op(t, row, col);
        lb = log_q.size(); fb = feat_q.size(); d0 = done_cnt;
        i_Op_Start = 1'b1; i_Op_Type = t; i_Row_Addr = row; i_Col_Addr = col;
        tick();
        i_Op_Start = 1'b0;
        i_Op_Type  = 2'($urandom);
        i_Row_Addr = 24'($urandom);
        i_Col_Addr = 13'($urandom);
        check_val({nm, "_busy"}, 32'(o_Op_Busy), 32'd1);
        if (t == 2'b11) check_val({nm, "_rsv_done"}, 32'(o_Op_Done), 32'd1);
        if (second && t != 2'b11) begin
            repeat (3) tick();
            i_Op_Start = 1'b1; i_Op_Type = 2'b10;
            tick();
            i_Op_Start = 1'b0;
        end
        n = 0;
        while (done_cnt == d0 && n < 20000) begin
            tick();
            n++;
        end
        check_val({nm, "_done_seen"}, 32'(done_cnt != d0), 32'd1);
        tick();
        check_val({nm, "_done_cnt"}, 32'(done_cnt - d0), 32'd1);
        check_val({nm, "_fail"}, 32'(done_fail), 32'(exp_fail));
        check_val({nm, "_timeout"}, 32'(done_to), 32'(exp_to));
        check_val({nm, "_status"}, 32'(o_Status), 32'(exp_status));
        check_val({nm, "_idle"}, 32'(o_Op_Busy), 32'd0);
        check_val({nm, "_ncmd"}, 32'(log_q.size() - lb), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && lb + k < log_q.size(); k++) begin
            check_val({nm, "_cmd"}, 32'(log_q[lb + k].cmd), 32'(exp_q[k].cmd));
            if (exp_q[k].chk_addr)
                check_val({nm, "_addr"}, 32'(log_q[lb + k].addr), 32'(exp_q[k].addr));
        end
        kp = 0;
        for (int k = lb; k < log_q.size(); k++) begin
            if (log_q[k].cmd == 8'h0F) begin
                if (kp > 0 && fb + kp - 1 < feat_q.size())
                    check_val({nm, "_poll_gap"},
                              32'((log_q[k].cyc - feat_q[fb + kp - 1] - 1) >= TB_POLL_GAP), 32'd1);
                kp++;
            end
        end
    endtask

    initial begin
        int d0, lb, n, nb;
        logic [1:0] t;
        logic [7:0] s;
        rst = 1'b1; i_Op_Start = 1'b0; i_Op_Type = 2'b00; i_Row_Addr = '0; i_Col_Addr = '0;
        stray_dv = 1'b0; stray_byte = 8'h00; cm_delay = 2; feat_delay = 3;
        checks = 0; failures = 0; exp_status = 8'h00;
        repeat (3) tick();
        check_val("rst_busy", 32'(o_Op_Busy), 32'd0);
        check_val("rst_done", 32'(o_Op_Done), 32'd0);
        check_val("rst_fail", 32'(o_Op_Fail), 32'd0);
        check_val("rst_dv", 32'(o_CM_DV), 32'd0);
        check_val("rst_cmd", 32'(o_Command), 32'd0);
        check_val("rst_addr", 32'(o_Addr_Data), 32'd0);
        check_val("rst_status", 32'(o_Status), 32'd0);
        rst = 1'b0;
        tick();

        stat_list = '{8'h00};
        run_op("prog", 2'b00, 24'h000123, 13'h0040, 1'b0);
        stat_list = '{8'h01, 8'h01, 8'h04};
        run_op("erase", 2'b10, 24'h00ABCD, 13'h0000, 1'b0);
        stat_list = '{8'h20};
        run_op("read_ecc", 2'b01, 24'h012345, 13'h1ABC, 1'b0);
        stat_list = '{8'h01, 8'h01, 8'h01, 8'h01};
        run_op("tmo_prog", 2'b00, 24'h000777, 13'h0011, 1'b0);
        run_op("tmo_read", 2'b01, 24'h000888, 13'h0022, 1'b0);

        // Abort while waiting on a status byte
        stat_list = '{8'h01, 8'h01, 8'h01, 8'h01};
        feat_delay = 12; d0 = done_cnt; lb = log_q.size();
        i_Op_Start = 1'b1; i_Op_Type = 2'b00; i_Row_Addr = 24'h000456; i_Col_Addr = 13'h0010;
        tick();
        i_Op_Start = 1'b0;
        n = 0;
        while (n < 500 && !(log_q.size() > lb && log_q[$].cmd == 8'h0F)) begin
            tick();
            n++;
        end
        check_val("abort_reach_poll", 32'(n < 500), 32'd1);
        repeat (2) tick();
        rst = 1'b1;
        #1;
        check_val("abort_busy", 32'(o_Op_Busy), 32'd0);
        check_val("abort_cmd", 32'(o_Command), 32'd0);
        check_val("abort_addr", 32'(o_Addr_Data), 32'd0);
        check_val("abort_status", 32'(o_Status), 32'd0);
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_val("abort_no_done", 32'(done_cnt - d0), 32'd0);
        exp_status = 8'h00; feat_delay = 3;
        stat_list = '{8'h01, 8'h00};
        run_op("post_rst", 2'b00, 24'h000123, 13'h0040, 1'b0);

        run_op("rsv", 2'b11, 24'h000001, 13'h0001, 1'b0);
        cm_delay = 51;
        stat_list = '{8'h01, 8'h08};
        run_op("slow_prog", 2'b00, 24'h00BEEF, 13'h0123, 1'b1);
        cm_delay = 2;

        stray_byte = 8'hFE; stray_dv = 1'b1;
        tick();
        stray_dv = 1'b0;
        tick();
        check_val("stray_ignored", 32'(o_Status), 32'(exp_status));
        check_val("cmd_hold", 32'(o_Command), 32'(exp_q[$].cmd));

        for (int r = 0; r < 20; r++) begin
            t = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            nb = int'($urandom_range(0, 3));
            stat_list.delete();
            for (int j = 0; j < nb; j++) begin
                s = 8'($urandom);
                s[0] = 1'b1;
                stat_list.push_back(s);
            end
            s = 8'($urandom);
            s[0] = 1'b0;
            stat_list.push_back(s);
            cm_delay   = int'($urandom_range(1, 6));
            feat_delay = int'($urandom_range(2, 9));
            run_op("rnd", t, 24'($urandom), 13'($urandom), 1'($urandom_range(0, 1)));
        end

        check_val("flags_only_with_done", 32'(flag_err), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
